// File: rtl/stopwatch_pkg.sv
// Shared state encoding for the stopwatch button/mode sequencer.
// The codes are visible on the state port, so keep them stable.
package stopwatch_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 3'd1;
  localparam logic [STATE_W-1:0] ST_LAP  = 3'd2;
  localparam logic [STATE_W-1:0] ST_STOP = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;
  localparam logic [STATE_W-1:0] ST_CLR  = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_LAP  = ST_LAP,
    S_STOP = ST_STOP,
    S_DONE = ST_DONE,
    S_CLR  = ST_CLR
  } state_e;

endpackage

// File: rtl/stopwatch_ctrl_fsm_btn_debounce.sv
// Raw push button conditioning: 2-FF synchroniser, stability debounce and
// a one-cycle press pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_r;
  logic [DB_W-1:0] cnt_r;
  logic            stable_r;
  logic            stable_d_r;
  logic            press_r;

  // synchronise, debounce and edge-detect the button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r     <= 2'b00;
      cnt_r      <= {DB_W{1'b0}};
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      press_r    <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], btn};
      // any sample agreeing with the stable level restarts the stability window
      if (sync_r[1] != stable_r) begin
        if (cnt_r == CNT_LAST) begin
          stable_r <= sync_r[1];
          cnt_r    <= {DB_W{1'b0}};
        end else begin
          cnt_r <= cnt_r + {{(DB_W-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_r <= {DB_W{1'b0}};
      end
      stable_d_r <= stable_r;
      press_r    <= stable_r & ~stable_d_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch mode sequencer: debounced buttons and time_out drive the
// run/lap/stop/done/clear state machine and the counter level controls.
module stopwatch_ctrl_fsm
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W            = 20,
  parameter int CLR_TICKS       = 2
) (
  input  logic               clk_100mhz,
  input  logic               rst,
  input  logic               tick_100hz,
  input  logic               btn_start,
  input  logic               btn_lap,
  input  logic               btn_clear,
  input  logic               time_out,
  output logic               sw_en,
  output logic               pause,
  output logic               clear,
  output logic [STATE_W-1:0] state
);

  localparam int CT_W = (CLR_TICKS > 1) ? $clog2(CLR_TICKS) : 1;
  localparam logic [CT_W-1:0] CT_LAST = CT_W'(CLR_TICKS - 1);

  logic start_evt_s, lap_evt_s, clear_evt_s, to_evt_s;
  logic start_act_s, lap_act_s, to_act_s;
  logic [1:0] to_sync_r;
  logic       to_prev_r;
  state_e     state_r, state_n_s;
  logic [CT_W-1:0] clr_cnt_r, clr_cnt_n_s;
  logic sw_en_r, pause_r, clear_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_start (
    .clk(clk_100mhz), .rst(rst), .btn(btn_start), .press(start_evt_s));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_lap (
    .clk(clk_100mhz), .rst(rst), .btn(btn_lap), .press(lap_evt_s));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_clear (
    .clk(clk_100mhz), .rst(rst), .btn(btn_clear), .press(clear_evt_s));

  assign to_evt_s = to_sync_r[1] & ~to_prev_r;

  // one event per cycle: clear > time_out > start > lap
  assign to_act_s    = to_evt_s & ~clear_evt_s;
  assign start_act_s = start_evt_s & ~clear_evt_s & ~to_evt_s;
  assign lap_act_s   = lap_evt_s & ~clear_evt_s & ~to_evt_s & ~start_evt_s;

  // next-state and CLR tick counting
  always_comb begin
    state_n_s   = state_r;
    clr_cnt_n_s = clr_cnt_r;
    if (clear_evt_s) begin
      state_n_s   = S_CLR;
      clr_cnt_n_s = {CT_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_act_s) state_n_s = S_RUN;
          else             state_n_s = S_IDLE;
        end
        S_RUN: begin
          if (to_act_s)         state_n_s = S_DONE;
          else if (start_act_s) state_n_s = S_STOP;
          else if (lap_act_s)   state_n_s = S_LAP;
          else                  state_n_s = S_RUN;
        end
        S_LAP: begin
          if (to_act_s)         state_n_s = S_DONE;
          else if (start_act_s) state_n_s = S_STOP;
          else if (lap_act_s)   state_n_s = S_RUN;
          else                  state_n_s = S_LAP;
        end
        S_STOP: begin
          if (start_act_s) state_n_s = S_RUN;
          else             state_n_s = S_STOP;
        end
        S_DONE: state_n_s = S_DONE;
        S_CLR: begin
          if (tick_100hz) begin
            if (clr_cnt_r == CT_LAST) begin
              state_n_s   = S_IDLE;
              clr_cnt_n_s = {CT_W{1'b0}};
            end else begin
              state_n_s   = S_CLR;
              clr_cnt_n_s = clr_cnt_r + {{(CT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_n_s = S_CLR;
          end
        end
        default: begin
          state_n_s   = S_IDLE;
          clr_cnt_n_s = {CT_W{1'b0}};
        end
      endcase
    end
  end

  // state, time_out conditioning and outputs decoded from the next state
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_r   <= S_IDLE;
      clr_cnt_r <= {CT_W{1'b0}};
      to_sync_r <= 2'b00;
      to_prev_r <= 1'b0;
      sw_en_r   <= 1'b0;
      pause_r   <= 1'b0;
      clear_r   <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      clr_cnt_r <= clr_cnt_n_s;
      to_sync_r <= {to_sync_r[0], time_out};
      to_prev_r <= to_sync_r[1];
      sw_en_r   <= (state_n_s == S_RUN) || (state_n_s == S_LAP);
      pause_r   <= (state_n_s == S_LAP);
      clear_r   <= (state_n_s == S_CLR);
    end
  end

  assign sw_en = sw_en_r;
  assign pause = pause_r;
  assign clear = clear_r;
  assign state = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Directed bench for stopwatch_ctrl_fsm with a short debounce window.
module tb_stopwatch_ctrl_fsm;
  import stopwatch_pkg::*;

  logic clk_100mhz = 1'b0;
  logic rst, tick_100hz, btn_start, btn_lap, btn_clear, time_out;
  logic sw_en, pause, clear;
  logic [2:0] state;
  int errors = 0;
  int checks = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  stopwatch_ctrl_fsm #(.DEBOUNCE_CYCLES(8), .DB_W(20), .CLR_TICKS(2)) dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .tick_100hz(tick_100hz),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .time_out(time_out), .sw_en(sw_en), .pause(pause), .clear(clear),
    .state(state));

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic s, input logic p, input logic c);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".sw_en"}, 32'(sw_en), 32'(s));
    chk({tag, ".pause"}, 32'(pause), 32'(p));
    chk({tag, ".clear"}, 32'(clear), 32'(c));
  endtask

  task automatic press(input logic s, input logic l, input logic c);
    btn_start = s; btn_lap = l; btn_clear = c;
    cyc(20);
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    cyc(14);
  endtask

  task automatic tick_pulse();
    tick_100hz = 1'b1;
    cyc(1);
    tick_100hz = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_100hz = 1'b0; btn_start = 1'b0; btn_lap = 1'b0;
    btn_clear = 1'b0; time_out = 1'b0;
    cyc(3);
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1);

    // 1: exact press latency of DEBOUNCE_CYCLES+4
    btn_start = 1'b1;
    cyc(11);
    chk("t1_lat11.sw_en", 32'(sw_en), 32'(1'b0));
    cyc(1);
    chk_all("t1_lat12", 3'd1, 1'b1, 1'b0, 1'b0);
    cyc(8);
    btn_start = 1'b0;
    cyc(14);
    chk_all("t1_release", 3'd1, 1'b1, 1'b0, 1'b0);

    // 2: lap toggling and a short glitch
    press(1'b0, 1'b1, 1'b0);
    chk_all("t2_lap", 3'd2, 1'b1, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    chk_all("t2_unlap", 3'd1, 1'b1, 1'b0, 1'b0);
    btn_start = 1'b1;
    cyc(5);
    btn_start = 1'b0;
    cyc(14);
    chk_all("t2_glitch", 3'd1, 1'b1, 1'b0, 1'b0);

    // 3: start beats lap in the same cycle
    press(1'b0, 1'b1, 1'b0);
    chk_all("t3_lap", 3'd2, 1'b1, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    chk_all("t3_both", 3'd3, 1'b0, 1'b0, 1'b0);

    // 4: time_out, ignored start, clear held for two ticks
    press(1'b1, 1'b0, 1'b0);
    chk_all("t4_run", 3'd1, 1'b1, 1'b0, 1'b0);
    time_out = 1'b1;
    cyc(4);
    chk_all("t4_done", 3'd4, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk_all("t4_done_start", 3'd4, 1'b0, 1'b0, 1'b0);
    time_out = 1'b0;
    cyc(3);
    btn_clear = 1'b1;
    cyc(11);
    tick_100hz = 1'b1;   // coincides with CLR entry, must not count
    cyc(1);
    tick_100hz = 1'b0;
    chk_all("t4_clr_entry", 3'd5, 1'b0, 1'b0, 1'b1);
    tick_pulse();
    chk_all("t4_clr_tick1", 3'd5, 1'b0, 1'b0, 1'b1);
    tick_pulse();
    chk_all("t4_clr_tick2", 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(6);
    btn_clear = 1'b0;
    cyc(14);
    chk_all("t4_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // 5: clear beats time_out; re-clear restarts the tick count
    press(1'b1, 1'b0, 1'b0);
    chk_all("t5_run", 3'd1, 1'b1, 1'b0, 1'b0);
    btn_clear = 1'b1;
    cyc(9);
    time_out = 1'b1;
    cyc(3);
    chk_all("t5_clr_vs_to", 3'd5, 1'b0, 1'b0, 1'b1);
    cyc(8);
    btn_clear = 1'b0;
    cyc(14);
    tick_pulse();
    chk_all("t5_tick1", 3'd5, 1'b0, 1'b0, 1'b1);
    time_out = 1'b0;
    press(1'b0, 1'b0, 1'b1);
    chk_all("t5_reclear", 3'd5, 1'b0, 1'b0, 1'b1);
    tick_pulse();
    chk_all("t5_restart", 3'd5, 1'b0, 1'b0, 1'b1);
    tick_pulse();
    chk_all("t5_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // 6: reset mid-CLR, then illegal state recovery
    btn_clear = 1'b1;
    cyc(12);
    chk_all("t6_clr", 3'd5, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    cyc(1);
    chk_all("t6_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    btn_clear = 1'b0;
    cyc(14);
    press(1'b1, 1'b0, 1'b0);
    chk_all("t6_run", 3'd1, 1'b1, 1'b0, 1'b0);
    force dut.state_r = state_e'(3'd6);
    cyc(1);
    release dut.state_r;
    cyc(1);
    chk_all("t6_illegal", 3'd0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
